mmio_timer: RTL and testbench
=============================

Name: mmio_timer

Overview:
- Memory-mapped timer peripheral on the CPU's data-memory port, in parallel with the instruction/data memory.
- Decodes a fixed address window and owns three registers: TH (reload), TL (counter) and TCON (control/status).
- Raises an interrupt request toward the CPU core.
- The CPU-side read mux selects this block's read data whenever `hit` is high.

Parameters:
- BASE_ADDR, 32'h4000_0000, base of the register window (word aligned).
- PRESCALE, 1, clock cycles per TL increment; legal range 1..65535.
- PS_W, 16, prescaler counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (low = reset asserted).
- Address  input  32  byte address from the CPU memory port.
- Write_data  input  32  store data.
- MemRead  input  1  read strobe.
- MemWrite  input  1  write strobe.
- Mem_data  output  32  read data; combinational; zero when not selected.
- hit  output  1  Address lies in the window (BASE..BASE+0x0F, or +0x13 with SYSTICK_EN).
- irq  output  1  interrupt request, equal to TCON[1] & TCON[2].

Behaviour:
- Register map, offsets from BASE_ADDR:
  - 0x0 TH: R/W.
  - 0x4 TL: R/W.
  - 0x8 TCON: bits [2:0] used, upper bits read 0.
  - 0xC: reserved, reads 0, writes ignored.
- Address[1:0] is ignored.
- Reset values: TH=0, TL=0, TCON=0, prescaler=0, irq=0. Mem_data is 0 while reset is asserted.
- TCON bits:
  - [0] EN: counting enable.
  - [1] IE: interrupt enable.
  - [2] IS: status. Set by hardware; write-1-to-clear; writing 0 has no effect.
- Reads: Mem_data = selected register when MemRead & hit, otherwise 0. Zero-cycle latency.
- Writes: take effect at the rising edge when MemWrite & hit.
- Prescaler:
  - Runs only while EN=1.
  - Counts 0..PRESCALE-1, then wraps to 0.
  - `tick` is asserted on the cycle the count equals PRESCALE-1.
  - Clearing EN resets the prescaler to 0 on the next edge.
  - PRESCALE=1 gives a tick on every cycle while EN=1.
- Counter, on each cycle with EN & tick:
  - TL != 32'hFFFF_FFFF: TL <= TL+1.
  - TL == 32'hFFFF_FFFF: TL <= TH, and IS <= 1 (IS is set regardless of IE).
- Priority when events coincide in the same cycle:
  - CPU write to TL beats the increment or reload.
  - A hardware IS set beats a CPU write-1-to-clear, so no overflow is lost.
  - A CPU write to TH in the overflow cycle: the reload uses the old TH.
  - A CPU write to TCON applies EN and IE immediately. The counter action for that edge uses the old EN.
- irq is combinational from registered TCON bits, so it is glitch-free. It stays high until software clears IS or clears IE.
- Reset mid-count: all state clears immediately (asynchronous). Counting resumes only after software sets EN again.
- MemRead and MemWrite together on a hit address: the write happens at the edge; read data shows the pre-write value.
- Accesses outside the window: hit=0, no state change.

Optional Feature:
- Macro: MMIO_TIMER_SYSTICK_EN.
- Defined:
  - Adds a free-running 32-bit SYSTICK register at offset 0x10, read-only.
  - Increments every clk cycle from reset, independent of EN and the prescaler.
  - Wraps 0xFFFF_FFFF -> 0.
  - Writes to it are ignored.
  - The window extends to 0x13.
- Undefined: no SYSTICK register; offset 0x10 is outside the window (hit=0).

Decomposition:
- Package mmio_timer_pkg holds:
  - Register offset constants: OFF_TH, OFF_TL, OFF_TCON, OFF_SYSTICK.
  - TCON bit indices: TCON_EN, TCON_IE, TCON_IS.
  - Default BASE_ADDR.
- Sub-module timer_prescaler: parameters PRESCALE and PS_W; inputs clk, reset, en; output tick.
- Register file and address decode stay in the top module.

Test Plan:
- Reset then read -> after reset goes low then high, reads of TH, TL and TCON return 0; irq=0; hit=1 for 0x4000_0008, hit=0 for 0x4000_0020.
- Overflow/reload, PRESCALE=1 -> write TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, TCON=0x3:
  - 2 cycles later TL=0xFFFF_FFF0, TCON reads 0x7, irq=1.
  - Write TCON=0x7 (W1C on IS) -> TCON reads 0x3, irq=0.
- Prescaler, PRESCALE=4 -> TL=0, EN=1; after 20 cycles TL=5; clear EN; hold 10 cycles; TL is still 5.
- Collision -> in the cycle TL wraps, CPU writes TCON=0x7:
  - IS remains 1 and irq stays 1.
  - Separately, a TL write of 0x1234 in an increment cycle reads back 0x1234.
- IE gating -> overflow with TCON=0x1: IS=1, irq=0. Then write TCON=0x3 -> irq=1 on the next cycle.
- MMIO_TIMER_SYSTICK_EN defined:
  - Read 0x4000_0010 at cycle N and again at N+10 -> difference of 10.
  - Write 0xDEAD to 0x4000_0010 -> value unaffected.
  - With the macro undefined: hit=0 at that address.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// ============================================================================
// Module   : mmio_timer_pkg
// Brief    : Shared register offsets, TCON bit indices and default window base
//            for the memory-mapped timer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mmio_timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_0010;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
// Module   : timer_prescaler
// Brief    : Divides clk by PRESCALE while enabled; tick marks the last count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module timer_prescaler #(
    parameter int PRESCALE = 1,
    parameter int PS_W     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [PS_W-1:0] c_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] r_cnt;

    assign tick = en && (r_cnt == c_LAST);

    // A disabled prescaler always restarts from zero so the first period after
    // re-enabling is a full PRESCALE cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!en || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PS_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_timer.sv
// ============================================================================
// Module   : mmio_timer
// Brief    : Memory-mapped reload timer (TH/TL/TCON) with interrupt request.
//            Define MMIO_TIMER_SYSTICK_EN to add a read-only free-running
//            SYSTICK register at offset 0x10.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          PRESCALE  = 1,
    parameter int          PS_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Mem_data,
    output logic        hit,
    output logic        irq
);

`ifdef MMIO_TIMER_SYSTICK_EN
    localparam logic [31:0] c_LAST_OFF = 32'h0000_0013;
`else
    localparam logic [31:0] c_LAST_OFF = 32'h0000_000F;
`endif

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;

    logic [31:0] w_off;
    logic [31:0] w_sel;
    logic        w_wr;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_tick;
    logic        w_ovf;

    // Addresses below the base wrap to huge offsets, so one compare bounds both ends.
    assign w_off = Address - BASE_ADDR;
    assign w_sel = {w_off[31:2], 2'b00};
    assign hit   = (w_off <= c_LAST_OFF);

    assign w_wr      = MemWrite && hit;
    assign w_wr_th   = w_wr && (w_sel == OFF_TH);
    assign w_wr_tl   = w_wr && (w_sel == OFF_TL);
    assign w_wr_tcon = w_wr && (w_sel == OFF_TCON);

    timer_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (r_tcon[TCON_EN]),
        .tick  (w_tick)
    );

    assign w_ovf = r_tcon[TCON_EN] && w_tick && (r_tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th   <= '0;
            r_tl   <= '0;
            r_tcon <= '0;
        end else begin
            if (w_wr_th) begin
                r_th <= Write_data;
            end

            // Reload reads the pre-write TH; a CPU write to TL overrides counting.
            if (w_wr_tl) begin
                r_tl <= Write_data;
            end else if (r_tcon[TCON_EN] && w_tick) begin
                r_tl <= w_ovf ? r_th : r_tl + 32'd1;
            end

            if (w_wr_tcon) begin
                r_tcon[TCON_EN] <= Write_data[TCON_EN];
                r_tcon[TCON_IE] <= Write_data[TCON_IE];
            end

            // Hardware set wins over write-1-to-clear so an overflow is never lost.
            if (w_ovf) begin
                r_tcon[TCON_IS] <= 1'b1;
            end else if (w_wr_tcon && Write_data[TCON_IS]) begin
                r_tcon[TCON_IS] <= 1'b0;
            end
        end
    end

`ifdef MMIO_TIMER_SYSTICK_EN
    logic [31:0] r_systick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end
`endif

    always_comb begin
        Mem_data = '0;
        if (MemRead && hit) begin
            case (w_sel)
                OFF_TH:      Mem_data = r_th;
                OFF_TL:      Mem_data = r_tl;
                OFF_TCON:    Mem_data = {29'd0, r_tcon};
`ifdef MMIO_TIMER_SYSTICK_EN
                OFF_SYSTICK: Mem_data = r_systick;
`endif
                default:     Mem_data = '0;
            endcase
        end
    end

    assign irq = r_tcon[TCON_IE] && r_tcon[TCON_IS];

endmodule

`default_nettype wire

// File: tb/tb_mmio_timer.sv
// ============================================================================
// Module   : tb_mmio_timer
// Brief    : Directed bench for mmio_timer with PRESCALE=1 and PRESCALE=4
//            instances sharing one CPU bus; reads are scoreboarded.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mmio_timer;
    import mmio_timer_pkg::*;

    localparam logic [31:0] c_BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] rdata1, rdata4;
    logic        hit1, hit4, irq1, irq4;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_pass   = 0;
    int   n_checks = 0;

    always #10 clk = ~clk;

    mmio_timer #(.BASE_ADDR(c_BASE), .PRESCALE(1), .PS_W(16)) u_dut1 (
        .clk        (clk),
        .reset      (rst_n),
        .Address    (addr),
        .Write_data (wdata),
        .MemRead    (mem_read),
        .MemWrite   (mem_write),
        .Mem_data   (rdata1),
        .hit        (hit1),
        .irq        (irq1)
    );

    mmio_timer #(.BASE_ADDR(c_BASE), .PRESCALE(4), .PS_W(16)) u_dut4 (
        .clk        (clk),
        .reset      (rst_n),
        .Address    (addr),
        .Write_data (wdata),
        .MemRead    (mem_read),
        .MemWrite   (mem_write),
        .Mem_data   (rdata4),
        .hit        (hit4),
        .irq        (irq4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Push the expected value, drive the read, then pop and compare once settled.
    task automatic rd(input string tag, input bit use4, input logic [31:0] a, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        addr     = a;
        mem_read = 1'b1;
        #1;
        e = sb.pop_front();
        check(e.tag, use4 ? rdata4 : rdata1, e.exp);
        mem_read = 1'b0;
    endtask

    // Called at a falling edge; the write lands on the following rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        wdata     = d;
        mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v0;
        exp_t        e;

        // Reset and initial state
        cycles(2);
        rd("rst_asserted_mem_data", 1'b0, c_BASE + 32'h0, 32'h0);
        rst_n = 1'b1;
        cycles(1);
        rd("rst_th", 1'b0, c_BASE + 32'h0, 32'h0);
        rd("rst_tl", 1'b0, c_BASE + 32'h4, 32'h0);
        rd("rst_tcon", 1'b0, c_BASE + 32'h8, 32'h0);
        rd("rst_reserved", 1'b0, c_BASE + 32'hC, 32'h0);
        check("rst_irq", {31'd0, irq1}, 32'h0);
        addr = c_BASE + 32'h8;
        #1 check("hit_tcon", {31'd0, hit1}, 32'h1);
        addr = c_BASE + 32'h20;
        #1 check("hit_outside", {31'd0, hit1}, 32'h0);
        cycles(1);

        // Overflow and reload, PRESCALE=1
        wr(c_BASE + 32'h0, 32'hFFFF_FFF0);
        wr(c_BASE + 32'h4, 32'hFFFF_FFFE);
        wr(c_BASE + 32'h8, 32'h3);
        cycles(2);
        rd("ovf_tl_reload", 1'b0, c_BASE + 32'h4, 32'hFFFF_FFF0);
        rd("ovf_tcon", 1'b0, c_BASE + 32'h8, 32'h7);
        check("ovf_irq", {31'd0, irq1}, 32'h1);
        wr(c_BASE + 32'h8, 32'h7);
        rd("w1c_tcon", 1'b0, c_BASE + 32'h8, 32'h3);
        check("w1c_irq", {31'd0, irq1}, 32'h0);

        // Overflow coincides with a write-1-to-clear of IS
        wr(c_BASE + 32'h4, 32'hFFFF_FFFF);
        wr(c_BASE + 32'h8, 32'h7);
        rd("coll_tcon", 1'b0, c_BASE + 32'h8, 32'h7);
        check("coll_irq", {31'd0, irq1}, 32'h1);
        rd("coll_tl_reload", 1'b0, c_BASE + 32'h4, 32'hFFFF_FFF0);

        // CPU write to TL beats the increment
        wr(c_BASE + 32'h4, 32'h0000_1234);
        rd("tl_write_wins", 1'b0, c_BASE + 32'h4, 32'h0000_1234);

        // IE gating
        wr(c_BASE + 32'h8, 32'h4);
        wr(c_BASE + 32'h4, 32'hFFFF_FFFF);
        wr(c_BASE + 32'h8, 32'h1);
        cycles(1);
        rd("ie_off_tcon", 1'b0, c_BASE + 32'h8, 32'h5);
        check("ie_off_irq", {31'd0, irq1}, 32'h0);
        wr(c_BASE + 32'h8, 32'h3);
        rd("ie_on_tcon", 1'b0, c_BASE + 32'h8, 32'h7);
        check("ie_on_irq", {31'd0, irq1}, 32'h1);

        // Read and write together: read shows the pre-write TH
        e.tag = "rw_old_th";
        e.exp = 32'hFFFF_FFF0;
        sb.push_back(e);
        addr      = c_BASE + 32'h0;
        wdata     = 32'h0000_A5A5;
        mem_write = 1'b1;
        mem_read  = 1'b1;
        #1;
        e = sb.pop_front();
        check(e.tag, rdata1, e.exp);
        @(negedge clk);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        rd("rw_new_th", 1'b0, c_BASE + 32'h0, 32'h0000_A5A5);

        // Write outside the window changes nothing
        wr(c_BASE + 32'h20, 32'h0);
        rd("outside_write_th", 1'b0, c_BASE + 32'h0, 32'h0000_A5A5);

        // Prescaler, PRESCALE=4 (dut4) alongside PRESCALE=1 (dut1)
        wr(c_BASE + 32'h8, 32'h4);
        wr(c_BASE + 32'h4, 32'h0);
        wr(c_BASE + 32'h8, 32'h1);
        cycles(20);
        rd("ps4_tl_after_20", 1'b1, c_BASE + 32'h4, 32'd5);
        wr(c_BASE + 32'h8, 32'h0);
        cycles(10);
        rd("ps4_tl_held", 1'b1, c_BASE + 32'h4, 32'd5);
        rd("ps1_tl_held", 1'b0, c_BASE + 32'h4, 32'd21);

        // Asynchronous reset in the middle of counting
        wr(c_BASE + 32'h8, 32'h1);
        cycles(3);
        #3 rst_n = 1'b0;
        rd("midrst_mem_data", 1'b0, c_BASE + 32'h4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("midrst_tl", 1'b0, c_BASE + 32'h4, 32'h0);
        rd("midrst_tcon", 1'b0, c_BASE + 32'h8, 32'h0);
        cycles(3);
        rd("midrst_tl_idle", 1'b0, c_BASE + 32'h4, 32'h0);

`ifdef MMIO_TIMER_SYSTICK_EN
        cycles(1);
        addr     = c_BASE + 32'h10;
        mem_read = 1'b1;
        #1;
        check("systick_hit", {31'd0, hit1}, 32'h1);
        v0       = rdata1;
        mem_read = 1'b0;
        cycles(10);
        rd("systick_delta10", 1'b0, c_BASE + 32'h10, v0 + 32'd10);
        cycles(1);
        wr(c_BASE + 32'h10, 32'h0000_DEAD);
        rd("systick_write_ignored", 1'b0, c_BASE + 32'h10, v0 + 32'd12);
`else
        cycles(1);
        v0 = c_BASE + 32'h10;
        addr = v0;
        #1 check("systick_hit_absent", {31'd0, hit1}, 32'h0);
        rd("systick_read_absent", 1'b0, v0, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
